mac_accumulator: RTL



---
 rtl/mac_accumulator.sv | 100 ++++++++++
 1 files changed

// File: rtl/mac_accumulator.sv
// Sums groups of unsigned 16-bit products (ended by prod_last); result valid two cycles after the last handshake.
// Result is held in HOLD until out_ready; input is stalled from the last product until the output handshake.
module mac_accumulator #(
    parameter int ACC_W    = 24,
    parameter int CNT_W    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             soft_clr,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [15:0]      prod,
    input  logic             prod_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic {ACC, HOLD} state_t;

    state_t            state;
    logic              s1_valid;
    logic [15:0]       s1_prod;
    logic              s1_last;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_sticky;

    logic [ACC_W:0]    wide;
    logic [ACC_W-1:0]  acc_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              ovf_nxt;
    logic              accumulate;
    logic              in_hs;

    // A pending last product blocks new input so groups never interleave.
    assign prod_ready = (state == ACC) & ~(s1_valid & s1_last) & ~soft_clr;
    assign in_hs      = prod_valid & prod_ready;
    assign accumulate = (state == ACC) & s1_valid;
    assign busy       = s1_valid | (cnt != '0) | (state == HOLD);

    assign wide    = {1'b0, acc} + {{(ACC_W + 1 - 16){1'b0}}, s1_prod};
    assign acc_nxt = (wide[ACC_W] && SATURATE) ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
    assign ovf_nxt = ovf_sticky | wide[ACC_W];
    assign cnt_nxt = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACC;
            s1_valid   <= 1'b0;
            s1_prod    <= '0;
            s1_last    <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_count  <= '0;
            out_ovf    <= 1'b0;
        end else begin
            s1_valid <= in_hs;
            if (in_hs) begin
                s1_prod <= prod;
                s1_last <= prod_last;
            end

            if (soft_clr) begin
                acc        <= '0;
                cnt        <= '0;
                ovf_sticky <= 1'b0;
                out_valid  <= 1'b0;
                state      <= ACC;
            end else if (accumulate) begin
                if (s1_last) begin
                    out_sum    <= acc_nxt;
                    out_count  <= cnt_nxt;
                    out_ovf    <= ovf_nxt;
                    out_valid  <= 1'b1;
                    state      <= HOLD;
                    acc        <= '0;
                    cnt        <= '0;
                    ovf_sticky <= 1'b0;
                end else begin
                    acc        <= acc_nxt;
                    cnt        <= cnt_nxt;
                    ovf_sticky <= ovf_nxt;
                end
            end else if (state == HOLD && out_ready) begin
                // Output data registers intentionally keep the last result.
                out_valid <= 1'b0;
                state     <= ACC;
            end
        end
    end

endmodule
